heat_column_engine: RTL and testbench

//  One column of the FPGA heat-diffusion grid; next-generation column worker.

---
 rtl/heat_column_engine_if.sv | 39 +++
 rtl/heat_column_engine.sv | 218 +++++++++++++++++++++
 tb/tb_heat_column_engine.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/heat_column_engine_if.sv
// Parent/column bus for heat_column_engine: step control, neighbour exchange,
// source/init programming and the VGA readout port.
interface heat_column_engine_if #(
   parameter int DATA_W   = 32,
   parameter int ROW_BITS = 8
);
   logic [ROW_BITS-1:0] height;
   logic                bnd_mode;
   logic [DATA_W-1:0]   alpha;
   logic                init_req;
   logic [DATA_W-1:0]   init_value;
   logic                src_en;
   logic [ROW_BITS-1:0] src_row;
   logic [DATA_W-1:0]   src_value;
   logic                start;
   logic [DATA_W-1:0]   node_left;
   logic [DATA_W-1:0]   node_right;
   logic [DATA_W-1:0]   node_center;
   logic [ROW_BITS-1:0] row_idx;
   logic                flag;
   logic                done_init;
   logic                rd_en;
   logic [ROW_BITS-1:0] rd_addr;
   logic                rd_ready;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;

   modport master (
      output height, bnd_mode, alpha, init_req, init_value, src_en, src_row,
             src_value, start, node_left, node_right, rd_en, rd_addr,
      input  node_center, row_idx, flag, done_init, rd_ready, rd_data, rd_valid
   );

   modport slave (
      input  height, bnd_mode, alpha, init_req, init_value, src_en, src_row,
             src_value, start, node_left, node_right, rd_en, rd_addr,
      output node_center, row_idx, flag, done_init, rd_ready, rd_data, rd_valid
   );
endinterface

// File: rtl/heat_column_engine.sv
// One column of the heat-diffusion grid: column memory, one Jacobi row update
// per start pulse, saturating fixed-point math and a readout port.
module heat_column_engine #(
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 27,
   parameter int ROW_BITS = 8,
   parameter bit SAT      = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   heat_column_engine_if.slave  bus
);
   localparam int DEPTH = 1 << ROW_BITS;
   localparam int LW    = DATA_W + 3;
   localparam int PW    = 2 * DATA_W + 3;
   localparam logic signed [PW-1:0] MAX_V = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_V = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_HOLD, S_RD, S_WAIT, S_COMP, S_WB
   } state_t;

   state_t                     state_q, state_d;
   logic [ROW_BITS-1:0]        row_q, row_d;
   logic [ROW_BITS-1:0]        height_q, height_d;
   logic                       flag_q, flag_d;
   logic                       done_q, done_d;
   logic                       rd_ready_q, rd_ready_d;
   logic                       rd_valid_q, rd_valid_d;
   logic signed [DATA_W-1:0]   center_q, center_d;
   logic signed [DATA_W-1:0]   down_q, down_d;
   logic signed [DATA_W-1:0]   up_q, up_d;
   logic signed [DATA_W-1:0]   left_q, left_d;
   logic signed [DATA_W-1:0]   right_q, right_d;
   logic signed [DATA_W-1:0]   unext_q, unext_d;

   logic signed [DATA_W-1:0]   mem [DEPTH];
   logic signed [DATA_W-1:0]   mem_rd_q;
   logic                       mem_we;
   logic [ROW_BITS-1:0]        mem_waddr;
   logic [ROW_BITS-1:0]        mem_raddr;
   logic signed [DATA_W-1:0]   mem_wdata;

   logic signed [DATA_W-1:0]   init_word;
   logic signed [DATA_W-1:0]   bnd_val;
   logic signed [DATA_W-1:0]   up_eff;
   logic signed [DATA_W-1:0]   dn_eff;
   logic signed [LW-1:0]       lap;
   logic signed [PW-1:0]       prod;
   logic signed [PW-1:0]       prod_sh;
   logic signed [PW-1:0]       sum;
   logic signed [DATA_W-1:0]   u_calc;
   logic signed [DATA_W-1:0]   u_next;
   logic                       src_hit;

   // Column storage: one write port, one registered read port (M10K style)
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      mem_rd_q <= mem[mem_raddr];
   end

   always_comb begin
      src_hit   = bus.src_en && (row_q == bus.src_row);
      init_word = src_hit ? $signed(bus.src_value) : $signed(bus.init_value);

      bnd_val = bus.bnd_mode ? center_q : '0;
      up_eff  = (row_q == height_q) ? bnd_val : up_q;
      dn_eff  = (row_q == '0) ? bnd_val : down_q;

      lap     = LW'(up_eff) + LW'(dn_eff) + LW'(left_q) + LW'(right_q)
              - (LW'(center_q) <<< 2);
      prod    = PW'(lap) * PW'($signed(bus.alpha));
      prod_sh = prod >>> FRAC_W;
      sum     = PW'(center_q) + prod_sh;

      u_calc = sum[DATA_W-1:0];
      if (SAT) begin
         if (sum > MAX_V) begin
            u_calc = MAX_V[DATA_W-1:0];
         end else if (sum < MIN_V) begin
            u_calc = MIN_V[DATA_W-1:0];
         end
      end
      u_next = src_hit ? $signed(bus.src_value) : u_calc;
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      height_d   = height_q;
      flag_d     = flag_q;
      done_d     = done_q;
      center_d   = center_q;
      down_d     = down_q;
      up_d       = up_q;
      left_d     = left_q;
      right_d    = right_q;
      unext_d    = unext_q;
      mem_we     = 1'b0;
      mem_waddr  = row_q;
      mem_wdata  = unext_q;
      mem_raddr  = bus.rd_addr;
      rd_valid_d = bus.rd_en && rd_ready_q;

      case (state_q)
         S_IDLE: begin
            if (bus.init_req) begin
               state_d  = S_INIT;
               row_d    = '0;
               height_d = bus.height;
            end
         end
         S_INIT: begin
            mem_we    = 1'b1;
            mem_wdata = init_word;
            if (row_q == '0) begin
               center_d = init_word;
            end
            if (row_q == height_q) begin
               state_d = S_HOLD;
               row_d   = '0;
               flag_d  = 1'b1;
               done_d  = 1'b1;
            end else begin
               row_d = row_q + ROW_BITS'(1);
            end
         end
         S_HOLD: begin
            if (bus.init_req) begin
               state_d  = S_INIT;
               row_d    = '0;
               height_d = bus.height;
               flag_d   = 1'b0;
               done_d   = 1'b0;
            end else if (bus.start) begin
               state_d = S_RD;
               flag_d  = 1'b0;
            end
         end
         S_RD: begin
            // On the top row fetch row 0, already holding its next-step value
            mem_raddr = (row_q == height_q) ? '0 : row_q + ROW_BITS'(1);
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            up_d    = mem_rd_q;
            left_d  = $signed(bus.node_left);
            right_d = $signed(bus.node_right);
            state_d = S_COMP;
         end
         S_COMP: begin
            unext_d = u_next;
            state_d = S_WB;
         end
         S_WB: begin
            mem_we  = 1'b1;
            down_d  = center_q;
            flag_d  = 1'b1;
            state_d = S_HOLD;
            if (row_q == height_q) begin
               row_d    = '0;
               // Single-row column: the fetched word predates this write
               center_d = (height_q == '0) ? unext_q : up_q;
            end else begin
               row_d    = row_q + ROW_BITS'(1);
               center_d = up_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rd_ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         height_q   <= '0;
         flag_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_ready_q <= 1'b0;
         rd_valid_q <= 1'b0;
         center_q   <= '0;
         down_q     <= '0;
         up_q       <= '0;
         left_q     <= '0;
         right_q    <= '0;
         unext_q    <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         height_q   <= height_d;
         flag_q     <= flag_d;
         done_q     <= done_d;
         rd_ready_q <= rd_ready_d;
         rd_valid_q <= rd_valid_d;
         center_q   <= center_d;
         down_q     <= down_d;
         up_q       <= up_d;
         left_q     <= left_d;
         right_q    <= right_d;
         unext_q    <= unext_d;
      end
   end

   assign bus.node_center = center_q;
   assign bus.row_idx     = row_q;
   assign bus.flag        = flag_q;
   assign bus.done_init   = done_q;
   assign bus.rd_ready    = rd_ready_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_valid_q ? mem_rd_q : '0;
endmodule

// File: tb/tb_heat_column_engine.sv
// Bench for heat_column_engine: a saturating and a wrapping instance share
// stimulus; readouts are scored against a row-by-row Jacobi reference model.
module tb_heat_column_engine;
   localparam int RB = 8;
   localparam logic [31:0] ONE = 32'h0800_0000;

   typedef struct packed {
      logic [31:0] sat;
      logic [31:0] wrap;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int unsigned checks = 0;
   int unsigned errors = 0;

   exp_t              sb_q[$];
   logic signed [31:0] m_sat [256];
   logic signed [31:0] m_wrap[256];
   logic signed [31:0] s_sat [256];
   logic signed [31:0] s_wrap[256];
   int unsigned        m_h;
   int unsigned        m_row;

   heat_column_engine_if #(.DATA_W(32), .ROW_BITS(RB)) bus_s ();
   heat_column_engine_if #(.DATA_W(32), .ROW_BITS(RB)) bus_w ();

   heat_column_engine #(.DATA_W(32), .FRAC_W(27), .ROW_BITS(RB), .SAT(1'b1)) u_dut_sat (
      .clk(clk), .reset(reset), .bus(bus_s.slave));
   heat_column_engine #(.DATA_W(32), .FRAC_W(27), .ROW_BITS(RB), .SAT(1'b0)) u_dut_wrap (
      .clk(clk), .reset(reset), .bus(bus_w.slave));

   assign bus_w.height     = bus_s.height;
   assign bus_w.bnd_mode   = bus_s.bnd_mode;
   assign bus_w.alpha      = bus_s.alpha;
   assign bus_w.init_req   = bus_s.init_req;
   assign bus_w.init_value = bus_s.init_value;
   assign bus_w.src_en     = bus_s.src_en;
   assign bus_w.src_row    = bus_s.src_row;
   assign bus_w.src_value  = bus_s.src_value;
   assign bus_w.start      = bus_s.start;
   assign bus_w.node_left  = bus_s.node_left;
   assign bus_w.node_right = bus_s.node_right;
   assign bus_w.rd_en      = bus_s.rd_en;
   assign bus_w.rd_addr    = bus_s.rd_addr;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] jacobi(input logic signed [31:0] up, dn, c, l, r, a,
                                          input bit sat);
      logic signed [127:0] lap, sum, hi, lo;
      hi  = 32'sh7FFF_FFFF;
      lo  = -hi - 1;
      lap = up;
      lap = lap + dn + l + r - 4 * c;
      sum = c;
      sum = sum + ((lap * a) >>> 27);
      if (sat && sum > hi) return hi[31:0];
      if (sat && sum < lo) return lo[31:0];
      return sum[31:0];
   endfunction

   task automatic model_step();
      int unsigned r;
      logic signed [31:0] bs, bw, us, uw, ds, dw, a, l, rt;
      r  = m_row;
      a  = $signed(bus_s.alpha);
      l  = $signed(bus_s.node_left);
      rt = $signed(bus_s.node_right);
      bs = bus_s.bnd_mode ? s_sat[r] : 32'sd0;
      bw = bus_s.bnd_mode ? s_wrap[r] : 32'sd0;
      us = (r == m_h) ? bs : s_sat[r+1];
      uw = (r == m_h) ? bw : s_wrap[r+1];
      ds = (r == 0) ? bs : s_sat[r-1];
      dw = (r == 0) ? bw : s_wrap[r-1];
      if (bus_s.src_en && r == int'(bus_s.src_row)) begin
         m_sat[r]  = $signed(bus_s.src_value);
         m_wrap[r] = $signed(bus_s.src_value);
      end else begin
         m_sat[r]  = jacobi(us, ds, s_sat[r], l, rt, a, 1'b1);
         m_wrap[r] = jacobi(uw, dw, s_wrap[r], l, rt, a, 1'b0);
      end
      if (r == m_h) begin
         m_row  = 0;
         s_sat  = m_sat;
         s_wrap = m_wrap;
      end else begin
         m_row = r + 1;
      end
   endtask

   task automatic do_init(input int unsigned h, input logic [31:0] val, input bit sen,
                          input int unsigned srow, input logic [31:0] sval, input bit with_start);
      int unsigned n = 0;
      bus_s.height     = RB'(h);
      bus_s.init_value = val;
      bus_s.src_en     = sen;
      bus_s.src_row    = RB'(srow);
      bus_s.src_value  = sval;
      bus_s.init_req   = 1'b1;
      bus_s.start      = with_start;
      @(posedge clk); #1;
      bus_s.init_req = 1'b0;
      bus_s.start    = 1'b0;
      check_eq("init_flag_clr", bus_s.flag, 0);
      while (!bus_s.flag && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("init_cycles", n, h + 1);
      check_eq("init_done", bus_s.done_init, 1);
      check_eq("init_row", bus_s.row_idx, 0);
      for (int unsigned r = 0; r <= h; r++) begin
         m_sat[r]  = (sen && r == srow) ? sval : val;
         m_wrap[r] = m_sat[r];
      end
      s_sat  = m_sat;
      s_wrap = m_wrap;
      m_h    = h;
      m_row  = 0;
      check_eq("init_center", bus_s.node_center, m_sat[0]);
   endtask

   task automatic do_step(input bit probe);
      int unsigned n = 0;
      bus_s.start = 1'b1;
      @(posedge clk); #1;
      bus_s.start = 1'b0;
      check_eq("step_flag_clr", bus_s.flag, 0);
      if (probe) begin
         bus_s.rd_en    = 1'b1;
         bus_s.rd_addr  = 8'd3;
         bus_s.init_req = 1'b1;
         @(posedge clk); #1;
         n++;
         bus_s.rd_en    = 1'b0;
         bus_s.init_req = 1'b0;
         @(posedge clk); #1;
         n++;
         check_eq("busy_rd_valid", bus_s.rd_valid, 0);
         check_eq("busy_rd_ready", bus_s.rd_ready, 0);
      end
      while (!bus_s.flag && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("step_latency", n, 4);
      model_step();
      check_eq("step_row", bus_s.row_idx, m_row);
      check_eq("step_center_sat", bus_s.node_center, s_sat[m_row]);
      check_eq("step_center_wrap", bus_w.node_center, s_wrap[m_row]);
   endtask

   task automatic rd_rows(input int unsigned lo, input int unsigned hi);
      exp_t e;
      check_eq("rd_ready_hold", bus_s.rd_ready, 1);
      for (int unsigned a = lo; a <= hi; a++) begin
         bus_s.rd_en   = 1'b1;
         bus_s.rd_addr = RB'(a);
         e.sat  = m_sat[a];
         e.wrap = m_wrap[a];
         sb_q.push_back(e);
         @(posedge clk); #1;
      end
      bus_s.rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("sb_drain", sb_q.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus_s.rd_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("rd_valid_unexpected", bus_s.rd_valid, 0);
         end else begin
            e = sb_q.pop_front();
            check_eq("rd_data_sat", bus_s.rd_data, e.sat);
            check_eq("rd_data_wrap", bus_w.rd_data, e.wrap);
            check_eq("rd_valid_wrap", bus_w.rd_valid, 1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      bus_s.height = '0;      bus_s.bnd_mode = 1'b0;  bus_s.alpha = '0;
      bus_s.init_req = 1'b0;  bus_s.init_value = '0;  bus_s.src_en = 1'b0;
      bus_s.src_row = '0;     bus_s.src_value = '0;   bus_s.start = 1'b0;
      bus_s.node_left = '0;   bus_s.node_right = '0;  bus_s.rd_en = 1'b0;
      bus_s.rd_addr = '0;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_flag", bus_s.flag, 0);
      check_eq("rst_done", bus_s.done_init, 0);
      check_eq("rst_row", bus_s.row_idx, 0);
      check_eq("rst_center", bus_s.node_center, 0);
      check_eq("rst_rd_valid", bus_s.rd_valid, 0);
      check_eq("rst_rd_ready", bus_s.rd_ready, 0);
      check_eq("rst_rd_data", bus_s.rd_data, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("idle_rd_ready", bus_s.rd_ready, 1);
      check_eq("idle_flag", bus_s.flag, 0);

      // Source column: init, readout, then eight steps at alpha 0.125
      do_init(7, 32'h0, 1'b1, 3, 32'h4000_0000, 1'b0);
      rd_rows(0, 7);
      bus_s.alpha = 32'h0100_0000;
      for (int i = 0; i < 8; i++) do_step(i == 0);
      rd_rows(0, 7);

      // Single-row column, both neighbours replaced by zero
      bus_s.node_left  = ONE;
      bus_s.node_right = ONE;
      do_init(0, ONE, 1'b0, 0, 32'h0, 1'b0);
      do_step(1'b0);
      do_step(1'b0);
      rd_rows(0, 0);

      // Uniform 1.0 field, insulated then zero boundary
      bus_s.bnd_mode = 1'b1;
      do_init(7, ONE, 1'b0, 0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) do_step(1'b0);
      rd_rows(0, 7);
      bus_s.bnd_mode = 1'b0;
      do_init(7, ONE, 1'b0, 0, 32'h0, 1'b1);
      for (int i = 0; i < 8; i++) do_step(1'b0);
      rd_rows(0, 7);

      // Overflow: row 3 center below saturated neighbours, alpha 1.0
      bus_s.bnd_mode   = 1'b1;
      bus_s.node_left  = 32'h7FFF_FFFF;
      bus_s.node_right = 32'h7FFF_FFFF;
      do_init(7, 32'h7FFF_FFFF, 1'b1, 3, 32'h7800_0000, 1'b0);
      bus_s.src_en = 1'b0;
      bus_s.alpha  = ONE;
      for (int i = 0; i < 8; i++) do_step(1'b0);
      rd_rows(0, 7);

      // Reset while the row is in its compute cycle
      bus_s.alpha = 32'h0100_0000;
      do_init(7, ONE, 1'b0, 0, 32'h0, 1'b0);
      bus_s.start = 1'b1;
      @(posedge clk); #1;
      bus_s.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_eq("abort_flag", bus_s.flag, 0);
      check_eq("abort_done", bus_s.done_init, 0);
      check_eq("abort_center", bus_s.node_center, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      bus_s.start = 1'b1;
      @(posedge clk); #1;
      bus_s.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_eq("post_rst_flag", bus_s.flag, 0);
      check_eq("post_rst_done", bus_s.done_init, 0);
      check_eq("post_rst_row", bus_s.row_idx, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
